// File: rtl/random_arbiter_pkg.sv
// random_pkg: shared constants for the random_arbiter slice.
//   - FSM state encodings (SEED, WARM, SERVE)
//   - LFSR width and the XNOR-LFSR lockup value
//   - legal_seed(): substitutes the default seed for the lockup value
package random_pkg;

  localparam int LFSR_W = 3;

  localparam logic [1:0] ST_SEED  = 2'd0;
  localparam logic [1:0] ST_WARM  = 2'd1;
  localparam logic [1:0] ST_SERVE = 2'd2;

  // An XNOR LFSR sticks forever once it holds all ones.
  localparam logic [LFSR_W-1:0] LOCKUP_VAL = 3'b111;

  function automatic logic [LFSR_W-1:0] legal_seed(
    input logic [LFSR_W-1:0] seed,
    input logic [LFSR_W-1:0] dflt
  );
    return (seed == LOCKUP_VAL) ? dflt : seed;
  endfunction

endpackage

// File: rtl/random_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req   - request vector
//   ptr   - index where the search starts (highest priority this cycle)
//   win   - one-hot winner (all zero when nothing requested)
//   idx   - binary index of the winner
//   found - at least one request was set
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [PW-1:0]   idx,
  output logic            found
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      int j;
      j = (int'(ptr) + i) % NREQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        win[j] = 1'b1;
        idx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/random_arbiter.sv
// random_arbiter: owns a 3-bit XNOR LFSR. Seeds it, lets it run WARMUP steps,
// then hands its value out to NREQ requesters in round-robin order.
//   clk, rst_n  - clock, asynchronous active-low reset
//   seed_req    - one-cycle pulse: reseed with seed_val (111 -> SEED_DEFAULT)
//   seed_val    - requested seed
//   req         - level request per requester
//   gnt         - registered one-hot grant pulse
//   rnd_data    - random value delivered with gnt, held otherwise
//   lfsr_load   - LFSR enable (load seed), registered
//   lfsr_seed   - LFSR seed value, registered
//   lfsr_data   - current LFSR state
//   busy        - high outside SERVE
//   lockup_err  - sticky: LFSR seen at 111 while serving
module random_arbiter
  import random_pkg::*;
#(
  parameter int                  NREQ         = 4,
  parameter int                  WARMUP       = 3,
  parameter logic [LFSR_W-1:0]   SEED_DEFAULT = 3'b001
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seed_req,
  input  logic [LFSR_W-1:0] seed_val,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   gnt,
  output logic [LFSR_W-1:0] rnd_data,
  output logic              lfsr_load,
  output logic [LFSR_W-1:0] lfsr_seed,
  input  logic [LFSR_W-1:0] lfsr_data,
  output logic              busy,
  output logic              lockup_err
);

  localparam int PW = $clog2(NREQ);

  logic [1:0]      state;
  logic [PW-1:0]   ptr;
  logic [3:0]      warm_cnt;

  logic [NREQ-1:0] pick_win;
  logic [PW-1:0]   pick_idx;
  logic            pick_found;
  logic [PW-1:0]   ptr_next;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .win   (pick_win),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign ptr_next = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);
  assign busy     = (state != ST_SERVE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_SEED;
      gnt        <= '0;
      rnd_data   <= '0;
      lfsr_load  <= 1'b1;
      lfsr_seed  <= SEED_DEFAULT;
      lockup_err <= 1'b0;
      ptr        <= '0;
      warm_cnt   <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register
      // in this block sees the pre-edge values, matching the hardware.
      gnt <= '0;  // grant is a one-cycle pulse
      case (state)
        ST_SEED: begin
          // lfsr_load is high for exactly this cycle; seed_req is ignored here.
          lfsr_load <= 1'b0;
          warm_cnt  <= '0;
          state     <= ST_WARM;
        end

        ST_WARM: begin
          warm_cnt <= warm_cnt + 4'd1;
          if (seed_req) begin
            state     <= ST_SEED;
            lfsr_load <= 1'b1;
            lfsr_seed <= legal_seed(seed_val, SEED_DEFAULT);
          end else if (warm_cnt == 4'(WARMUP - 1)) begin
            state <= ST_SERVE;
          end
        end

        ST_SERVE: begin
          if (lfsr_data == LOCKUP_VAL) begin
            // Stuck LFSR: flag it and recover with the known-good seed.
            lockup_err <= 1'b1;
            state      <= ST_SEED;
            lfsr_load  <= 1'b1;
            lfsr_seed  <= SEED_DEFAULT;
          end else if (seed_req) begin
            state     <= ST_SEED;
            lfsr_load <= 1'b1;
            lfsr_seed <= legal_seed(seed_val, SEED_DEFAULT);
          end else if (pick_found) begin
            gnt      <= pick_win;
            rnd_data <= lfsr_data;
            ptr      <= ptr_next;
          end
        end

        default: begin
          state     <= ST_SEED;
          lfsr_load <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_random_arbiter.sv
// Directed bench for random_arbiter. A behavioural XNOR LFSR
// (001->011->110->101->010->100->000->001) is attached to the DUT's
// lfsr_load/lfsr_seed/lfsr_data; force_lock overrides its output with 111.
module tb_random_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       seed_req;
  logic [2:0] seed_val;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [2:0] rnd_data;
  logic       lfsr_load;
  logic [2:0] lfsr_seed;
  logic [2:0] lfsr_data;
  logic       busy;
  logic       lockup_err;

  logic [2:0] lfsr_q = 3'b000;
  logic       force_lock;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  // Environment: the LFSR the arbiter controls.
  always @(posedge clk) begin
    if (lfsr_load) lfsr_q <= lfsr_seed;
    else           lfsr_q <= {lfsr_q[1:0], ~(lfsr_q[2] ^ lfsr_q[1])};
  end
  assign lfsr_data = force_lock ? 3'b111 : lfsr_q;

  random_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seed_req   (seed_req),
    .seed_val   (seed_val),
    .req        (req),
    .gnt        (gnt),
    .rnd_data   (rnd_data),
    .lfsr_load  (lfsr_load),
    .lfsr_seed  (lfsr_seed),
    .lfsr_data  (lfsr_data),
    .busy       (busy),
    .lockup_err (lockup_err)
  );

  // Advance one rising edge and settle; outputs are read here, inputs changed here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset with no requests and run to the first SERVE cycle (pointer 0,
  // lfsr_data = 101 after three warm steps from 001).
  task automatic bring_up();
    rst_n = 1'b0; req = '0; seed_req = 1'b0; seed_val = '0; force_lock = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (4) step();
  endtask

  task automatic test_reset();
    logic [2:0] exp_r [7];
    exp_r = '{3'b101, 3'b010, 3'b100, 3'b000, 3'b001, 3'b011, 3'b110};
    rst_n = 1'b0; req = 4'b0001; seed_req = 1'b0; seed_val = '0; force_lock = 1'b0;
    repeat (2) step();
    vectors++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rst_gnt got=%b exp=0000", gnt); end
    vectors++; if (rnd_data !== 3'b000) begin errors++; $display("FAIL rst_rnd got=%b exp=000", rnd_data); end
    vectors++; if (lfsr_load !== 1'b1) begin errors++; $display("FAIL rst_load got=%b exp=1", lfsr_load); end
    vectors++; if (lfsr_seed !== 3'b001) begin errors++; $display("FAIL rst_seed got=%b exp=001", lfsr_seed); end
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy got=%b exp=1", busy); end
    vectors++; if (lockup_err !== 1'b0) begin errors++; $display("FAIL rst_lockup got=%b exp=0", lockup_err); end
    rst_n = 1'b1;
    step();  // SEED -> WARM
    vectors++; if (lfsr_load !== 1'b0) begin errors++; $display("FAIL warm_load got=%b exp=0", lfsr_load); end
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL warm_busy got=%b exp=1", busy); end
    repeat (2) step();
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL warm3_busy got=%b exp=1", busy); end
    step();  // first SERVE cycle, no grant yet
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL serve_busy got=%b exp=0", busy); end
    vectors++; if (gnt !== 4'b0000) begin errors++; $display("FAIL serve1_gnt got=%b exp=0000", gnt); end
    for (int i = 0; i < 7; i++) begin
      step();
      vectors++; if (gnt !== 4'b0001) begin errors++; $display("FAIL seq_gnt[%0d] got=%b exp=0001", i, gnt); end
      vectors++; if (rnd_data !== exp_r[i]) begin errors++; $display("FAIL seq_rnd[%0d] got=%b exp=%b", i, rnd_data, exp_r[i]); end
    end
  endtask

  task automatic test_full_load();
    logic [3:0] exp_g [5];
    logic [2:0] exp_r [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_r = '{3'b101, 3'b010, 3'b100, 3'b000, 3'b001};
    bring_up();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++; if (gnt !== exp_g[i]) begin errors++; $display("FAIL full_gnt[%0d] got=%b exp=%b", i, gnt, exp_g[i]); end
      vectors++; if (rnd_data !== exp_r[i]) begin errors++; $display("FAIL full_rnd[%0d] got=%b exp=%b", i, rnd_data, exp_r[i]); end
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy[%0d] got=%b exp=0", i, busy); end
    end
  endtask

  task automatic test_sparse();
    logic [3:0] exp_g [3];
    logic [2:0] exp_r [3];
    exp_g = '{4'b0010, 4'b1000, 4'b0010};
    exp_r = '{3'b101, 3'b010, 3'b100};
    bring_up();
    req = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (gnt !== exp_g[i]) begin errors++; $display("FAIL sparse_gnt[%0d] got=%b exp=%b", i, gnt, exp_g[i]); end
      vectors++; if (rnd_data !== exp_r[i]) begin errors++; $display("FAIL sparse_rnd[%0d] got=%b exp=%b", i, rnd_data, exp_r[i]); end
    end
    req = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++; if (gnt !== 4'b0000) begin errors++; $display("FAIL idle_gnt[%0d] got=%b exp=0000", i, gnt); end
      vectors++; if (rnd_data !== 3'b100) begin errors++; $display("FAIL idle_rnd[%0d] got=%b exp=100", i, rnd_data); end
    end
  endtask

  task automatic test_reseed();
    bring_up();
    req = 4'b0001;
    step();
    vectors++; if (gnt !== 4'b0001 || rnd_data !== 3'b101) begin errors++; $display("FAIL rs_pre got=%b/%b exp=0001/101", gnt, rnd_data); end
    seed_req = 1'b1; seed_val = 3'b010;
    step();
    seed_req = 1'b0;
    vectors++; if (lfsr_load !== 1'b1) begin errors++; $display("FAIL rs_load got=%b exp=1", lfsr_load); end
    vectors++; if (lfsr_seed !== 3'b010) begin errors++; $display("FAIL rs_seed got=%b exp=010", lfsr_seed); end
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL rs_busy got=%b exp=1", busy); end
    vectors++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rs_gnt got=%b exp=0000", gnt); end
    step();  // LFSR takes 010, WARM begins
    vectors++; if (lfsr_load !== 1'b0) begin errors++; $display("FAIL rs_load_off got=%b exp=0", lfsr_load); end
    repeat (2) step();
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL rs_warm_busy got=%b exp=1", busy); end
    step();  // warm steps 100, 000, 001 -> SERVE
    vectors++; if (busy !== 1'b0 || gnt !== 4'b0000) begin errors++; $display("FAIL rs_serve got=%b/%b exp=0/0000", busy, gnt); end
    step();
    vectors++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rs_gnt1 got=%b exp=0001", gnt); end
    vectors++; if (rnd_data !== 3'b001) begin errors++; $display("FAIL rs_rnd1 got=%b exp=001", rnd_data); end
  endtask

  task automatic test_seed_illegal();
    bring_up();
    seed_req = 1'b1; seed_val = 3'b111;
    step();
    seed_req = 1'b0;
    vectors++; if (lfsr_seed !== 3'b001) begin errors++; $display("FAIL ill_seed got=%b exp=001", lfsr_seed); end
    vectors++; if (lfsr_load !== 1'b1) begin errors++; $display("FAIL ill_load got=%b exp=1", lfsr_load); end
    // In SEED: request must be ignored.
    seed_req = 1'b1; seed_val = 3'b110;
    step();
    seed_req = 1'b0;
    vectors++; if (lfsr_load !== 1'b0) begin errors++; $display("FAIL seedst_load got=%b exp=0", lfsr_load); end
    vectors++; if (lfsr_seed !== 3'b001) begin errors++; $display("FAIL seedst_seed got=%b exp=001", lfsr_seed); end
    // In WARM: request is honoured.
    seed_req = 1'b1; seed_val = 3'b100;
    step();
    seed_req = 1'b0;
    vectors++; if (lfsr_load !== 1'b1) begin errors++; $display("FAIL warmrs_load got=%b exp=1", lfsr_load); end
    vectors++; if (lfsr_seed !== 3'b100) begin errors++; $display("FAIL warmrs_seed got=%b exp=100", lfsr_seed); end
  endtask

  task automatic test_lockup_and_mid_reset();
    bring_up();
    req = 4'b0001;
    force_lock = 1'b1;
    step();
    force_lock = 1'b0;
    vectors++; if (lockup_err !== 1'b1) begin errors++; $display("FAIL lock_err got=%b exp=1", lockup_err); end
    vectors++; if (lfsr_load !== 1'b1) begin errors++; $display("FAIL lock_load got=%b exp=1", lfsr_load); end
    vectors++; if (lfsr_seed !== 3'b001) begin errors++; $display("FAIL lock_seed got=%b exp=001", lfsr_seed); end
    vectors++; if (gnt !== 4'b0000) begin errors++; $display("FAIL lock_gnt got=%b exp=0000", gnt); end
    repeat (4) step();  // SEED, 3x WARM -> SERVE with lfsr_data 101
    step();
    vectors++; if (gnt !== 4'b0001 || rnd_data !== 3'b101) begin errors++; $display("FAIL lock_regnt got=%b/%b exp=0001/101", gnt, rnd_data); end
    vectors++; if (lockup_err !== 1'b1) begin errors++; $display("FAIL lock_sticky got=%b exp=1", lockup_err); end
    // Reset while a grant is showing: must drop without waiting for a clock.
    rst_n = 1'b0;
    #1;
    vectors++; if (gnt !== 4'b0000) begin errors++; $display("FAIL mid_gnt got=%b exp=0000", gnt); end
    vectors++; if (lfsr_load !== 1'b1) begin errors++; $display("FAIL mid_load got=%b exp=1", lfsr_load); end
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got=%b exp=1", busy); end
    vectors++; if (lockup_err !== 1'b0) begin errors++; $display("FAIL mid_lockup got=%b exp=0", lockup_err); end
    vectors++; if (rnd_data !== 3'b000) begin errors++; $display("FAIL mid_rnd got=%b exp=000", rnd_data); end
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; seed_req = 1'b0; seed_val = '0; force_lock = 1'b0;
    #1;
    test_reset();
    test_full_load();
    test_sparse();
    test_reseed();
    test_seed_illegal();
    test_lockup_and_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
